ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have no parameters; all scancode constants come from the shared package.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clrn  input  1  reset, synchronous and active-low.
REQ-004 data  input  8  FIFO head byte from ps2_keyboard.
REQ-005 ready  input  1  FIFO non-empty flag from ps2_keyboard.
REQ-006 overflow  input  1  FIFO overflow flag from ps2_keyboard.
REQ-007 nextdata_n  output  1  active-low pop strobe to ps2_keyboard.
REQ-008 key_valid  output  1  one-cycle pulse marking a decoded key event.
REQ-009 key_code  output  8  scancode of the event, excluding prefixes.
REQ-010 key_ext  output  1  event was preceded by E0.
REQ-011 key_release  output  1  event was preceded by F0 (break).
REQ-012 key_repeat  output  1  make event is a typematic repeat of cur_key.
REQ-013 key_count  output  8  count of new (non-repeat) make events.
REQ-014 cur_key  output  8  code of the held key; 0 when none is held.
REQ-015 shift, ctrl, caps  output  1 each  modifier state.
REQ-016 ovf_err  output  1  sticky FIFO-overflow indicator.

Function
REQ-017 The FSM SHALL have three states: IDLE -> ACK -> DECODE -> IDLE.
- IDLE: nextdata_n=1; when ready=1, latch data into byte_r and go to ACK.
- ACK: nextdata_n=0 for exactly one cycle, then go to DECODE.
- DECODE: nextdata_n=1; process byte_r, then return to IDLE.
REQ-018 nextdata_n SHALL be registered and SHALL never be low for two consecutive cycles.
REQ-019 Throughput SHALL be at most one byte per 3 cycles, with no byte skipped or read twice.
REQ-020 A byte sampled in IDLE at edge k SHALL produce key_valid high between edges k+2 and k+3.
REQ-021 Byte E0 SHALL set ext_f, byte F0 SHALL set brk_f, and neither SHALL produce an event.
REQ-022 Bytes 00 and FF SHALL clear ext_f and brk_f and SHALL produce no event.
REQ-023 Any other byte SHALL pulse key_valid with the following, then clear both flags:
- key_code=byte
- key_ext=ext_f
- key_release=brk_f
REQ-024 key_code, key_ext, key_release and key_repeat SHALL hold their values until the next event.
REQ-025 New make (code != cur_key): key_repeat=0, cur_key=code, key_count+1, wrapping FF->00.
REQ-026 Repeat make (code == cur_key, cur_key != 0): key_repeat=1, key_count unchanged.
REQ-027 Break of code == cur_key SHALL set cur_key=0; a break of any other code SHALL leave cur_key unchanged.
REQ-028 Modifier codes:
- shift = left-shift held (12) OR right-shift held (59); make sets, break clears each side independently.
- ctrl tracks 14, with or without the E0 prefix.
- caps toggles on a new make of 58 only; repeats and breaks have no effect.
REQ-029 Modifier codes SHALL still produce events and SHALL still update cur_key and key_count.
REQ-030 ovf_err SHALL be set in any cycle with overflow=1 and SHALL be cleared only by reset.
REQ-031 Overflow SHALL NOT stall or alter decoding.

Reset
REQ-032 When clrn=0 at a clock edge, in any state, the block SHALL enter IDLE and set:
- nextdata_n=1
- key_valid, key_ext, key_release, key_repeat = 0
- key_code, key_count, cur_key = 0
- shift, ctrl, caps, ovf_err = 0
- ext_f, brk_f, byte_r = 0
REQ-033 A reset asserted during ACK SHALL force nextdata_n=1 at that same edge; the byte being popped is discarded.

Structure
REQ-034 Package ps2_pkg SHALL hold:
- FSM state encoding;
- constants SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CTRL=14, SC_CAPS=58.
REQ-035 One sub-module, ps2_mod_tracker, SHALL own shift, ctrl and caps, and SHALL be fed by the event signals.
REQ-036 ps2_keyboard and scancode_ram SHALL be instantiated outside this block.

Verification
REQ-037 The bench SHALL cover these scenarios:
- 1C, F0, 1C -> two events: (1C, release=0) then (1C, release=1); key_count=1; cur_key 1C then 00.
- E0, 75, E0, F0, 75 -> events have ext=1 with release 0 then 1; key_count=1.
- 1C, 1C, 1C -> repeat=0,1,1; key_count=1.
- 58, F0, 58, 58 -> caps goes 1, stays 1, then goes 0.
- 256 distinct new makes -> key_count returns to 00.
- ready held high with a 3-byte FIFO -> nextdata_n low exactly 3 single cycles spaced 3 apart.
- clrn low during ACK -> nextdata_n=1 at that edge and all outputs reset.
- overflow pulsed -> ovf_err stays 1 until reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 key controller shared definitions.
// FSM encoding and scancode constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUL    = 8'h00;
  localparam logic [7:0] SC_ERR    = 8'hFF;

  // 00 and FF are keyboard error/filler bytes, not keys.
  function automatic logic is_filler(input logic [7:0] b);
    return (b == SC_NUL) || (b == SC_ERR);
  endfunction

endpackage

// File: rtl/ps2_mod_tracker.sv
// Modifier state tracker for the PS/2 key controller.
// Shift sides are held separately so either release leaves the other.
import ps2_pkg::*;

module ps2_mod_tracker (
  input  logic       clk,
  input  logic       clrn,
  input  logic       i_evt,
  input  logic [7:0] i_code,
  input  logic       i_rel,
  input  logic       i_new_make,
  output logic       o_shift,
  output logic       o_ctrl,
  output logic       o_caps
);

  logic r_lsh;
  logic r_rsh;
  logic r_ctrl;
  logic r_caps;

  // Update modifier flags on each decoded key event.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_lsh  <= 1'b0;
      r_rsh  <= 1'b0;
      r_ctrl <= 1'b0;
      r_caps <= 1'b0;
    end else if (i_evt) begin
      unique case (1'b1)
        (i_code == SC_LSHIFT): r_lsh  <= ~i_rel;
        (i_code == SC_RSHIFT): r_rsh  <= ~i_rel;
        (i_code == SC_CTRL):   r_ctrl <= ~i_rel;
        (i_code == SC_CAPS): begin
          if (i_new_make) r_caps <= ~r_caps;
        end
        default: ;
      endcase
    end
  end

  assign o_shift = r_lsh | r_rsh;
  assign o_ctrl  = r_ctrl;
  assign o_caps  = r_caps;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode decoder: pops the keyboard FIFO and emits key events.
// One byte per IDLE -> ACK -> DECODE pass; prefixes fold into flags.
import ps2_pkg::*;

module ps2_key_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_repeat,
  output logic [7:0] key_count,
  output logic [7:0] cur_key,
  output logic       shift,
  output logic       ctrl,
  output logic       caps,
  output logic       ovf_err
);

  state_t     r_state;
  logic [7:0] r_byte;
  logic       r_ext_f;
  logic       r_brk_f;
  logic       r_nd_n;
  logic       r_valid;
  logic [7:0] r_code;
  logic       r_kext;
  logic       r_krel;
  logic       r_krep;
  logic [7:0] r_cnt;
  logic [7:0] r_cur;
  logic       r_ovf;

  logic w_dec;
  logic w_is_ext;
  logic w_is_brk;
  logic w_is_nul;
  logic w_evt;
  logic w_new_make;

  assign w_dec    = (r_state == ST_DECODE);
  assign w_is_ext = (r_byte == SC_EXT);
  assign w_is_brk = (r_byte == SC_BRK);
  assign w_is_nul = is_filler(r_byte);
  assign w_evt    = w_dec & ~(w_is_ext | w_is_brk | w_is_nul);
  assign w_new_make = w_evt & ~r_brk_f & (r_byte != r_cur);

  // Fetch/acknowledge/decode FSM with all event outputs registered.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_byte  <= 8'h00;
      r_ext_f <= 1'b0;
      r_brk_f <= 1'b0;
      r_nd_n  <= 1'b1;
      r_valid <= 1'b0;
      r_code  <= 8'h00;
      r_kext  <= 1'b0;
      r_krel  <= 1'b0;
      r_krep  <= 1'b0;
      r_cnt   <= 8'h00;
      r_cur   <= 8'h00;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_nd_n <= 1'b1;
          if (ready) begin
            r_byte  <= data;
            r_nd_n  <= 1'b0;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_nd_n  <= 1'b1;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_nd_n  <= 1'b1;
          r_state <= ST_IDLE;
          unique case (1'b1)
            w_is_ext: r_ext_f <= 1'b1;
            w_is_brk: r_brk_f <= 1'b1;
            w_is_nul: begin
              r_ext_f <= 1'b0;
              r_brk_f <= 1'b0;
            end
            default: begin
              r_valid <= 1'b1;
              r_code  <= r_byte;
              r_kext  <= r_ext_f;
              r_krel  <= r_brk_f;
              r_ext_f <= 1'b0;
              r_brk_f <= 1'b0;
              // A break is never a repeat.
              if (r_brk_f) begin
                r_krep <= 1'b0;
                if (r_byte == r_cur) r_cur <= 8'h00;
              end else if (r_byte != r_cur) begin
                r_krep <= 1'b0;
                r_cur  <= r_byte;
                r_cnt  <= r_cnt + 8'd1;
              end else begin
                r_krep <= 1'b1;
              end
            end
          endcase
        end
        default: begin
          r_nd_n  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!clrn) r_ovf <= 1'b0;
    else if (overflow) r_ovf <= 1'b1;
  end

  ps2_mod_tracker u_mod (
    .clk        (clk),
    .clrn       (clrn),
    .i_evt      (w_evt),
    .i_code     (r_byte),
    .i_rel      (r_brk_f),
    .i_new_make (w_new_make),
    .o_shift    (shift),
    .o_ctrl     (ctrl),
    .o_caps     (caps)
  );

  assign nextdata_n  = r_nd_n;
  assign key_valid   = r_valid;
  assign key_code    = r_code;
  assign key_ext     = r_kext;
  assign key_release = r_krel;
  assign key_repeat  = r_krep;
  assign key_count   = r_cnt;
  assign cur_key     = r_cur;
  assign ovf_err     = r_ovf;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: FIFO model feeding a scancode reference.
// Directed scenarios plus randomized byte streams.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic [7:0] data = 8'h00;
  logic       nextdata_n, key_valid;
  logic       key_ext, key_release, key_repeat;
  logic       shift, ctrl, caps, ovf_err;
  logic [7:0] key_code, key_count, cur_key;

  ps2_key_ctrl dut (
    .clk(clk), .clrn(clrn), .data(data),
    .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid),
    .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_repeat(key_repeat),
    .key_count(key_count), .cur_key(cur_key),
    .shift(shift), .ctrl(ctrl), .caps(caps),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic [7:0] cnt;
    logic [7:0] cur;
    logic       sh;
    logic       ct;
    logic       cp;
  } rec_t;

  int checks = 0;
  int failures = 0;

  logic [7:0] fq[$];
  rec_t expq[$];
  rec_t alog[$];
  rec_t last = '0;

  logic       m_ext, m_brk, m_lsh, m_rsh, m_ctrl, m_caps;
  logic [7:0] m_cur, m_cnt;
  logic       nd1 = 1'b1;
  logic       nd2 = 1'b1;
  logic [7:0] tbl [16];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0;
    m_ctrl = 0; m_caps = 0; m_cur = 0; m_cnt = 0;
    expq.delete();
    last = '0;
  endtask

  // Reference: what one popped byte means to a keyboard user.
  task automatic model_byte(input logic [7:0] b);
    rec_t r;
    logic nm;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 0; m_brk = 0;
    end else begin
      nm = !m_brk && (b != m_cur);
      r.code = b;
      r.ext = m_ext;
      r.rel = m_brk;
      r.rep = !m_brk && !nm;
      if (nm) begin
        m_cur = b;
        m_cnt = m_cnt + 8'd1;
      end
      if (m_brk && b == m_cur) m_cur = 8'h00;
      if (b == 8'h12) m_lsh = !m_brk;
      if (b == 8'h59) m_rsh = !m_brk;
      if (b == 8'h14) m_ctrl = !m_brk;
      if (b == 8'h58 && nm) m_caps = !m_caps;
      r.cnt = m_cnt;
      r.cur = m_cur;
      r.sh = m_lsh | m_rsh;
      r.ct = m_ctrl;
      r.cp = m_caps;
      expq.push_back(r);
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Keyboard FIFO: pops while nextdata_n is low.
  always @(negedge clk) begin
    logic [7:0] b;
    if (!nextdata_n && fq.size() > 0) begin
      b = fq.pop_front();
      model_byte(b);
    end
    ready = (fq.size() > 0);
    data = ready ? fq[0] : 8'h00;
  end

  // Per-cycle output comparison against the reference.
  always @(negedge clk) begin
    rec_t a;
    a = {key_code, key_ext, key_release, key_repeat,
         key_count, cur_key, shift, ctrl, caps};
    if (key_valid === 1'b1) begin
      check("latency_pop_to_valid", {31'b0, nd2}, 32'd0);
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", a);
      end else begin
        last = expq.pop_front();
      end
      alog.push_back(a);
    end
    check("outputs", {2'b0, a}, {2'b0, last});
    check("nd_single_cycle", {31'b0, nd1 | nextdata_n}, 32'd1);
    nd2 = nd1;
    nd1 = nextdata_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    model_reset();
    fq.delete();
    alog.delete();
    tick();
    tick();
    clrn = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    while (fq.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (fq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", fq.size());
    end
    repeat (6) tick();
  endtask

  initial begin
    int lows[$];
    int k;
    tbl[0] = 8'hE0; tbl[1] = 8'hF0; tbl[2] = 8'h00;
    tbl[3] = 8'hFF; tbl[4] = 8'h12; tbl[5] = 8'h59;
    tbl[6] = 8'h14; tbl[7] = 8'h58; tbl[8] = 8'h1C;
    tbl[9] = 8'h1C; tbl[10] = 8'h1D; tbl[11] = 8'h75;
    tbl[12] = 8'h12; tbl[13] = 8'h58; tbl[14] = 8'hF0;
    tbl[15] = 8'hF0;
    model_reset();
    repeat (3) tick();
    check("reset_nd", {31'b0, nextdata_n}, 32'd1);
    check("reset_outs",
          {key_valid, key_code, key_ext, key_release,
           key_repeat, key_count, cur_key, shift, ctrl,
           caps, ovf_err}, 32'd0);
    clrn = 1'b1;
    tick();

    // 1C, F0, 1C: make then break
    do_reset();
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("mb_nev", alog.size(), 2);
    if (alog.size() >= 2) begin
      check("mb_ev0", {alog[0].code, alog[0].rel, alog[0].cur},
            {8'h1C, 1'b0, 8'h1C});
      check("mb_ev1", {alog[1].code, alog[1].rel, alog[1].cur},
            {8'h1C, 1'b1, 8'h00});
    end
    check("mb_count", key_count, 8'd1);
    check("mb_cur", cur_key, 8'h00);

    // E0 75 / E0 F0 75: extended make and break
    do_reset();
    push(8'hE0); push(8'h75);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check("ext_nev", alog.size(), 2);
    if (alog.size() >= 2) begin
      check("ext_ev0", {alog[0].ext, alog[0].rel}, 2'b10);
      check("ext_ev1", {alog[1].ext, alog[1].rel}, 2'b11);
    end
    check("ext_count", key_count, 8'd1);

    // Typematic repeats
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain();
    check("rep_nev", alog.size(), 3);
    if (alog.size() >= 3)
      check("rep_seq",
            {alog[0].rep, alog[1].rep, alog[2].rep}, 3'b011);
    check("rep_count", key_count, 8'd1);

    // Caps lock toggling
    do_reset();
    push(8'h58); push(8'hF0); push(8'h58); push(8'h58);
    drain();
    check("caps_nev", alog.size(), 3);
    if (alog.size() >= 3)
      check("caps_seq",
            {alog[0].cp, alog[1].cp, alog[2].cp}, 3'b110);

    // 256 new makes wrap key_count
    do_reset();
    for (int i = 0; i < 256; i++)
      push(8'h01 + 8'(i % 200));
    drain();
    check("wrap_nev", alog.size(), 256);
    check("wrap_count", key_count, 8'h00);

    // Three queued bytes: single-cycle pops spaced by 3
    do_reset();
    push(8'h1C); push(8'h1D); push(8'h1E);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!nextdata_n) lows.push_back(i);
    end
    check("pop_n", lows.size(), 3);
    if (lows.size() == 3) begin
      check("pop_gap0", lows[1] - lows[0], 3);
      check("pop_gap1", lows[2] - lows[1], 3);
    end
    drain();

    // Reset while acknowledging a byte
    do_reset();
    push(8'h1C);
    k = 0;
    while (nextdata_n && k < 10) begin
      tick();
      k++;
    end
    check("ack_seen", {31'b0, nextdata_n}, 32'd0);
    clrn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("ack_rst_nd", {31'b0, nextdata_n}, 32'd1);
    check("ack_rst_outs",
          {key_valid, key_code, key_ext, key_release,
           key_repeat, key_count, cur_key, shift, ctrl,
           caps, ovf_err}, 32'd0);
    tick();
    clrn = 1'b1;
    repeat (8) tick();
    check("ack_discard", key_count, 8'd0);

    // Sticky overflow
    do_reset();
    check("ovf_init", {31'b0, ovf_err}, 32'd0);
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    check("ovf_set", {31'b0, ovf_err}, 32'd1);
    push(8'h1C); push(8'h33);
    drain();
    check("ovf_hold", {31'b0, ovf_err}, 32'd1);
    check("ovf_nostall", key_count, 8'd2);
    do_reset();
    check("ovf_clear", {31'b0, ovf_err}, 32'd0);

    // Random byte streams with random gaps
    do_reset();
    for (int i = 0; i < 600; i++) begin
      push(tbl[$urandom_range(0, 15)]);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 8)) tick();
    end
    drain();
    check("rand_leftover", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
